// File: rtl/bcd_counter_2d.sv
// ---------------------------------------------------------------------------
// bcd_counter_2d
//
// Two-digit synchronous BCD up/down counter (00..99) with parallel load.
// A load is rejected as a whole when either load digit is outside 0..9.
// The counter feeds a BCD-to-Excess-3 converter stage downstream, one
// converter per digit output.
//
// Ports:
//   clk       in   rising-edge clock for all state
//   rst       in   synchronous active-high reset (q = 00, load_err = 0)
//   en        in   count enable
//   up        in   direction: 1 = increment, 0 = decrement
//   load      in   parallel load request (takes priority over en)
//   d_ones    in   [3:0] load value, ones digit
//   d_tens    in   [3:0] load value, tens digit
//   q_ones    out  [3:0] registered ones digit, always 0..9
//   q_tens    out  [3:0] registered tens digit, always 0..9
//   tc        out  combinational terminal count, for cascading
//   load_err  out  registered one-cycle flag for a rejected load
// ---------------------------------------------------------------------------
module bcd_counter_2d (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] d_ones,
    input  logic [3:0] d_tens,
    output logic [3:0] q_ones,
    output logic [3:0] q_tens,
    output logic       tc,
    output logic       load_err
);

    logic load_ok;
    logic ones_max;
    logic ones_min;
    logic tens_max;
    logic tens_min;

    // Both digits must be valid BCD; otherwise nothing is loaded.
    assign load_ok  = (d_ones <= 4'd9) && (d_tens <= 4'd9);

    assign ones_max = (q_ones == 4'd9);
    assign ones_min = (q_ones == 4'd0);
    assign tens_max = (q_tens == 4'd9);
    assign tens_min = (q_tens == 4'd0);

    // Terminal count is deliberately not gated by load or rst so a cascaded
    // stage sees it purely as a function of en, up and the current count.
    assign tc = en & ((up & tens_max & ones_max) | (~up & tens_min & ones_min));

    // Priority: rst > load > en > hold. load_err defaults low every edge so
    // it is a single-cycle pulse unless invalid loads arrive back to back.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_ones   <= '0;
            q_tens   <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    q_ones <= d_ones;
                    q_tens <= d_tens;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (up) begin
                    if (ones_max) begin
                        q_ones <= '0;
                        q_tens <= tens_max ? 4'd0 : q_tens + 4'd1;
                    end else begin
                        q_ones <= q_ones + 4'd1;
                    end
                end else begin
                    if (ones_min) begin
                        q_ones <= 4'd9;
                        q_tens <= tens_min ? 4'd9 : q_tens - 4'd1;
                    end else begin
                        q_ones <= q_ones - 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_2d.sv
module tb_bcd_counter_2d;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] d_ones, d_tens;
    logic [3:0] q_ones, q_tens;
    logic       tc, load_err;

    always #5 clk = ~clk;

    bcd_counter_2d dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .d_ones   (d_ones),
        .d_tens   (d_tens),
        .q_ones   (q_ones),
        .q_tens   (q_tens),
        .tc       (tc),
        .load_err (load_err)
    );

    typedef struct {
        logic [3:0] t;
        logic [3:0] o;
        logic       err;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] d_tens;
        logic [3:0] d_ones;
        logic [3:0] e_tens;
        logic [3:0] e_ones;
        logic       e_err;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   model = 0;
    bit   model_valid = 1'b0;

    // Downstream BCD-to-Excess-3 stage fed by q_ones.
    function automatic logic [3:0] ex3(input logic [3:0] b);
        return b + 4'd3;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic e, input logic u,
                        input logic [3:0] dt, input logic [3:0] dv,
                        input int exp_val, input logic exp_err, input string tag);
        exp_t x;
        rst = r; load = l; en = e; up = u; d_tens = dt; d_ones = dv;
        #1;
        if (model_valid)
            check({tag, " tc"}, int'(tc),
                  (e && ((u && model == 99) || (!u && model == 0))) ? 1 : 0);
        sb.push_back('{t: 4'(exp_val / 10), o: 4'(exp_val % 10), err: exp_err});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check({tag, " q_tens"}, int'(q_tens), int'(x.t));
        check({tag, " q_ones"}, int'(q_ones), int'(x.o));
        check({tag, " load_err"}, int'(load_err), int'(x.err));
        check({tag, " ex3"}, int'(ex3(q_ones)), int'(x.o) + 3);
        model = exp_val;
        model_valid = 1'b1;
    endtask

    vec_t tbl[18];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tbl = '{
            '{1'b0, 1'b1, 1'b0, 1'b0, 4'd2,  4'd7,  4'd2, 4'd7, 1'b0}, // load 27
            '{1'b0, 1'b1, 1'b0, 1'b1, 4'd3,  4'd12, 4'd2, 4'd7, 1'b1}, // bad ones
            '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  4'd8,  4'd5, 4'd8, 1'b0}, // load 58
            '{1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 4'd0,  4'd5, 4'd8, 1'b1}, // bad tens, en ignored
            '{1'b0, 1'b1, 1'b0, 1'b0, 4'd9,  4'd10, 4'd5, 4'd8, 1'b1}, // back-to-back bad
            '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd0,  4'd5, 4'd8, 1'b0}, // hold, flag clears
            '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0,  4'd9,  4'd0, 4'd9, 1'b0}, // load 09
            '{1'b0, 1'b1, 1'b1, 1'b1, 4'd9,  4'd0,  4'd9, 4'd0, 1'b0}, // load beats en: 90
            '{1'b0, 1'b1, 1'b0, 1'b1, 4'd7,  4'd2,  4'd7, 4'd2, 1'b0}, // load 72
            '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'd7, 4'd3, 1'b0}, // count to 73
            '{1'b1, 1'b1, 1'b1, 1'b1, 4'd1,  4'd1,  4'd0, 4'd0, 1'b0}, // rst beats load
            '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'd0, 4'd1, 1'b0}, // resume: 01
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'd0, 4'd0, 1'b0}, // down to 00
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd0,  4'd9, 4'd9, 1'b0}, // wrap 00->99
            '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  4'd0, 4'd0, 1'b0}, // turn around 99->00
            '{1'b0, 1'b1, 1'b0, 1'b0, 4'd10, 4'd10, 4'd0, 4'd0, 1'b1}, // bad load
            '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  4'd0, 4'd0, 1'b0}, // rst clears flag
            '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  4'd0, 4'd0, 1'b0}  // hold at 00, no tc
        };

        rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; d_tens = '0; d_ones = '0;

        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 0, 1'b0, "reset");

        for (int i = 0; i < 100; i++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, (model + 1) % 100, 1'b0, "up");

        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 4'd5, 45, 1'b0, "ld45");
        for (int i = 0; i < 47; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, (model + 99) % 100, 1'b0, "down");
        check("down end", model, 98);

        for (int i = 0; i < 18; i++)
            step(tbl[i].rst, tbl[i].load, tbl[i].en, tbl[i].up,
                 tbl[i].d_tens, tbl[i].d_ones,
                 int'(tbl[i].e_tens) * 10 + int'(tbl[i].e_ones), tbl[i].e_err,
                 $sformatf("vec%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
